// File: rtl/rf_multiport.sv
// rf_multiport: DEPTH x DATA_W register file with two write ports and two
// combinational read ports. Port 1 wins a same-address write conflict. An
// optional write-to-read bypass and an optional hard-wired zero entry are
// available. A clear sequencer zeroes one entry per cycle after reset or
// when clr is pulsed, and writes are only accepted once the sweep is done.
module rf_multiport #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              we0,
    input  logic [ADDR_W-1:0] wa0,
    input  logic [DATA_W-1:0] wd0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] wa1,
    input  logic [DATA_W-1:0] wd1,
    input  logic [ADDR_W-1:0] ra1,
    input  logic [ADDR_W-1:0] ra2,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2,
    output logic              ready,
    output logic [ADDR_W-1:0] clr_ptr
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_nextState;
    logic [ADDR_W-1:0] r_clrPtr;
    logic [ADDR_W-1:0] w_nextPtr;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              w_wrEn0;
    logic              w_wrEn1;

    // A write to entry 0 is dropped when it is hard-wired to zero; port 0
    // also yields to port 1 when both target the same entry.
    assign w_wrEn1 = (r_state == RUN) && we1 && !((ZERO_REG != 0) && (wa1 == '0));
    assign w_wrEn0 = (r_state == RUN) && we0 && !((ZERO_REG != 0) && (wa0 == '0))
                     && !(we1 && (wa1 == wa0));

    assign ready   = (r_state == RUN);
    assign clr_ptr = r_clrPtr;

    // Read value as seen this cycle: zero during the sweep and for the zero
    // entry, otherwise the in-flight write data (port 1 first) or the array.
    function automatic logic [DATA_W-1:0] readPort(input logic [ADDR_W-1:0] ra);
        logic [DATA_W-1:0] v;
        v = r_mem[ra];
        if (r_state != RUN) begin
            v = '0;
        end else if ((ZERO_REG != 0) && (ra == '0)) begin
            v = '0;
        end else if ((BYPASS != 0) && we1 && (wa1 == ra)) begin
            v = wd1;
        end else if ((BYPASS != 0) && we0 && (wa0 == ra)) begin
            v = wd0;
        end
        return v;
    endfunction

    // State and sweep pointer register; reset restarts the sweep from entry 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= CLEAR;
            r_clrPtr <= '0;
        end else begin
            r_state  <= w_nextState;
            r_clrPtr <= w_nextPtr;
        end
    end

    // Sweep advances one entry per cycle and hands over to RUN after the
    // last entry; clr in RUN starts a fresh sweep.
    always_comb begin
        w_nextState = r_state;
        w_nextPtr   = r_clrPtr;
        case (r_state)
            CLEAR: begin
                if (r_clrPtr == ADDR_W'(DEPTH - 1)) begin
                    w_nextState = RUN;
                    w_nextPtr   = '0;
                end else begin
                    w_nextPtr = r_clrPtr + ADDR_W'(1);
                end
            end
            RUN: begin
                if (clr) begin
                    w_nextState = CLEAR;
                    w_nextPtr   = '0;
                end
            end
            default: begin
                w_nextState = CLEAR;
                w_nextPtr   = '0;
            end
        endcase
    end

    // Array update: the sweep zeroes the current entry, RUN performs the
    // qualified port writes (including in the cycle clr is seen).
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (r_state == CLEAR) begin
                r_mem[r_clrPtr] <= '0;
            end else begin
                if (w_wrEn0) begin
                    r_mem[wa0] <= wd0;
                end
                if (w_wrEn1) begin
                    r_mem[wa1] <= wd1;
                end
            end
        end
    end

    // Both read ports share the same combinational lookup.
    always_comb begin
        rd1 = readPort(ra1);
        rd2 = readPort(ra2);
    end

endmodule
